button_debouncer: RTL and testbench

//  - Conditions one raw board push-button for the cpu's regWriteEnableButton input.
//  - Synchronises the button, rejects bounce, and emits exactly one clk-wide pulse per debounced press,
//    so a held button no longer writes every 50 MHz cycle.
//  - Sits between the FPGA pin and the cpu top; one instance per button.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/input_synchronizer.sv | 35 +++
 rtl/button_debouncer.sv | 162 ++++++++++++++++
 tb/tb_button_debouncer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings and small helpers shared by the cpu board-input conditioning logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_synchronizer.sv
// input_synchronizer: two-flop synchroniser for asynchronous board inputs (buttons, switches).
// RESET_VALUE should be the idle level of the pin so reset never looks like an input event.
module input_synchronizer #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise, debounce and edge-detect one push-button into a one-cycle strobe.
// Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to add held-button auto-repeat pulses.
module button_debouncer
   import cpu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
   parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
   parameter int unsigned REPEAT_DELAY      = 25000000,
   parameter int unsigned REPEAT_PERIOD     = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic buttonIn,
   output logic buttonPulse,
   output logic buttonLevel,
   output logic buttonBusy
);

   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
   end
   if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_repeat
      $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
   end

   db_state_e       state_q;
   db_state_e       state_d;
   logic [DB_W-1:0] count_q;
   logic [DB_W-1:0] count_d;
   logic            pulse_q;
   logic            pulse_d;
   logic            level_q;
   logic            level_d;
   logic            pin_sync;
   logic            pressed_sync;
   logic            rep_fire;

   input_synchronizer #(
      .WIDTH       (1),
      .RESET_VALUE (BUTTON_ACTIVE_LOW)
   ) u_sync (
      .clk      (clk),
      .rst_n    (reset),
      .async_in (buttonIn),
      .sync_out (pin_sync)
   );

   assign pressed_sync = pin_sync ^ BUTTON_ACTIVE_LOW;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         DB_IDLE: begin
            if (pressed_sync) begin
               state_d = DB_PRESS_WAIT;
               count_d = DB_ONE;
            end
         end
         DB_PRESS_WAIT: begin
            if (!pressed_sync) begin
               state_d = DB_IDLE;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = DB_PRESSED;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DB_PRESSED: begin
            if (!pressed_sync) begin
               state_d = DB_RELEASE_WAIT;
               count_d = DB_ONE;
            end
         end
         DB_RELEASE_WAIT: begin
            if (pressed_sync) begin
               state_d = DB_PRESSED;
               count_d = '0;
            end else if (count_q == DB_LAST) begin
               state_d = DB_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = DB_IDLE;
            count_d = '0;
         end
      endcase
   end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
   localparam int unsigned      REP_W      = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);

   logic [REP_W-1:0] rep_count_q;
   logic [REP_W-1:0] rep_count_d;
   logic             rep_phase_q;  // 0: waiting for first repeat, 1: periodic repeats
   logic             rep_phase_d;

   always_comb begin
      rep_count_d = '0;
      rep_phase_d = 1'b0;
      rep_fire    = 1'b0;
      if (state_q == DB_PRESSED) begin
         if (rep_count_q == (rep_phase_q ? REP_PERIOD : REP_DELAY)) begin
            rep_fire    = 1'b1;
            rep_count_d = REP_W'(1);
            rep_phase_d = 1'b1;
         end else begin
            rep_count_d = rep_count_q + 1'b1;
            rep_phase_d = rep_phase_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_count_q <= '0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_count_q <= rep_count_d;
         rep_phase_q <= rep_phase_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      level_d = (state_q == DB_PRESSED) || (state_q == DB_RELEASE_WAIT);
      // level_q trails state_q by a cycle, so it is still low only in the first PRESSED cycle after PRESS_WAIT
      pulse_d = ((state_q == DB_PRESSED) && !level_q) || rep_fire;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DB_IDLE;
         count_q <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   assign buttonPulse = pulse_q;
   assign buttonLevel = level_q;
   assign buttonBusy  = (state_q == DB_PRESS_WAIT) || (state_q == DB_RELEASE_WAIT);

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and random stimulus for button_debouncer, checked cycle by cycle
// against a run-length reference model. Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to expect repeats.
module tb_button_debouncer;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic buttonIn;
   logic buttonPulse;
   logic buttonLevel;
   logic buttonBusy;

   always #5 clk = ~clk;

   button_debouncer #(
      .DEBOUNCE_CYCLES   (D),
      .BUTTON_ACTIVE_LOW (1'b1),
      .REPEAT_DELAY      (RD),
      .REPEAT_PERIOD     (RP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .buttonIn    (buttonIn),
      .buttonPulse (buttonPulse),
      .buttonLevel (buttonLevel),
      .buttonBusy  (buttonBusy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: pressed samples reach the debouncer two edges late; a level flips once
   // D consecutive samples disagree with it; outputs appear one edge after the decision.
   bit hist[$];
   bit m_acc;
   int m_opp;
   int m_h;
   bit m_rose;
   bit m_pulse;
   bit m_level;
   bit m_busy;

   // Per-scenario observation logs
   int pulse_log[$];
   int level_hi_cnt;
   int level_lo_cnt;
   int busy_cnt;
   int rise_cyc;
   int fall_cyc;
   logic prev_level = 1'b0;

   task automatic check_bit(string tag, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_list(string tag, input int got[$], input int exp[$]);
      int n;
      check_int({tag, "_count"}, got.size(), exp.size());
      n = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = 0; i < n; i++) check_int({tag, "_cycle"}, got[i], exp[i]);
   endtask

   task automatic model_reset();
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      m_acc   = 1'b0;
      m_opp   = 0;
      m_h     = 0;
      m_rose  = 1'b0;
      m_pulse = 1'b0;
      m_level = 1'b0;
      m_busy  = 1'b0;
   endtask

   task automatic model_edge(input bit pin);
      bit s;
      bit prs;
      bit fire;
      hist.push_back(~pin);
      s    = hist.pop_front();
      prs  = m_acc && (m_opp == 0);
      fire = REP_EN && prs && (m_h >= RD) && (((m_h - RD) % RP) == 0);
      m_pulse = m_rose || fire;
      m_level = m_acc;
      m_rose  = 1'b0;
      if (s == m_acc) begin
         m_opp = 0;
      end else begin
         m_opp++;
         if (m_opp == D) begin
            m_acc  = s;
            m_opp  = 0;
            m_rose = s;
         end
      end
      if (m_acc && (m_opp == 0)) m_h = prs ? m_h + 1 : 0;
      else m_h = 0;
      m_busy = (m_opp != 0);
   endtask

   task automatic clear_logs();
      pulse_log.delete();
      level_hi_cnt = 0;
      level_lo_cnt = 0;
      busy_cnt     = 0;
      rise_cyc     = -1;
      fall_cyc     = -1;
   endtask

   task automatic tick();
      logic pin;
      pin = buttonIn;
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) model_edge(pin);
      #1;
      check_bit("pulse", buttonPulse, m_pulse);
      check_bit("level", buttonLevel, m_level);
      check_bit("busy", buttonBusy, m_busy);
      $display("cycle %0d: in=%b pulse=%b level=%b busy=%b", cyc, pin, buttonPulse, buttonLevel, buttonBusy);
      if (buttonPulse === 1'b1) pulse_log.push_back(cyc);
      if (buttonLevel === 1'b1) level_hi_cnt++;
      else level_lo_cnt++;
      if (buttonBusy === 1'b1) busy_cnt++;
      if ((buttonLevel === 1'b1) && (prev_level === 1'b0)) rise_cyc = cyc;
      if ((buttonLevel === 1'b0) && (prev_level === 1'b1)) fall_cyc = cyc;
      prev_level = buttonLevel;
   endtask

   task automatic reset_now(string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_bit({tag, "_pulse"}, buttonPulse, 1'b0);
      check_bit({tag, "_level"}, buttonLevel, 1'b0);
      check_bit({tag, "_busy"}, buttonBusy, 1'b0);
      prev_level = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int f;
      int exp_q[$];

      // Reset with the pin reading pressed: outputs must be low before any clock edge
      reset    = 1'b1;
      buttonIn = 1'b0;
      #1;
      reset_now("reset");
      buttonIn = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      repeat (4) tick();

      // Clean press: 12 low samples then release
      clear_logs();
      e = cyc + 1;
      buttonIn = 1'b0;
      repeat (12) tick();
      buttonIn = 1'b1;
      repeat (12) tick();
      exp_q = {e + 6};
      if (REP_EN) exp_q.push_back(e + 14);
      check_list("clean_pulse", pulse_log, exp_q);
      check_int("clean_level_rise", rise_cyc, e + 6);
      check_int("clean_level_fall", fall_cyc, e + 18);

      // Press bounce: never D stable samples
      clear_logs();
      buttonIn = 1'b0; repeat (2) tick();
      buttonIn = 1'b1; tick();
      buttonIn = 1'b0; repeat (3) tick();
      buttonIn = 1'b1; repeat (10) tick();
      check_int("bounce_pulses", pulse_log.size(), 0);
      check_int("bounce_level_high", level_hi_cnt, 0);

      // Release glitch while PRESSED
      clear_logs();
      e = cyc + 1;
      buttonIn = 1'b0;
      repeat (10) tick();
      exp_q = {e + 6};
      check_list("glitch_press_pulse", pulse_log, exp_q);
      clear_logs();
      buttonIn = 1'b1; repeat (2) tick();
      buttonIn = 1'b0; repeat (6) tick();
      check_int("glitch_pulses", pulse_log.size(), 0);
      check_int("glitch_level_low", level_lo_cnt, 0);
      check_int("glitch_busy_cycles", busy_cnt, 2);
      buttonIn = 1'b1;
      repeat (12) tick();

      // Reset in PRESS_WAIT with count 2, button held through reset
      e = cyc + 1;
      buttonIn = 1'b0;
      repeat (4) tick();
      check_bit("rstmid_busy_before", buttonBusy, 1'b1);
      reset_now("rstmid");
      repeat (2) tick();
      reset = 1'b1;
      clear_logs();
      f = cyc + 1;
      repeat (8) tick();
      buttonIn = 1'b1;
      repeat (12) tick();
      exp_q = {f + 6};
      check_list("rstmid_pulse", pulse_log, exp_q);

      // Long hold: auto-repeat pulses when enabled
      clear_logs();
      e = cyc + 1;
      buttonIn = 1'b0;
      repeat (22) tick();
      buttonIn = 1'b1;
      repeat (12) tick();
      exp_q = {e + 6};
      if (REP_EN) begin
         exp_q.push_back(e + 14);
         exp_q.push_back(e + 17);
         exp_q.push_back(e + 20);
         exp_q.push_back(e + 23);
      end
      check_list("repeat_pulses", pulse_log, exp_q);

      // Random runs of pin levels, with one asynchronous reset in the middle
      for (int r = 0; r < 40; r++) begin
         buttonIn = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 2 * D + 3)) tick();
      end
      buttonIn = 1'b0;
      repeat ($urandom_range(1, 6)) tick();
      reset_now("rand_reset");
      tick();
      reset = 1'b1;
      for (int r = 0; r < 40; r++) begin
         buttonIn = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 3 * D + 8)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
